// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - LCD raster timing generator; LCD_TEST_PATTERN_EN adds an rgb colour-bar output
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 21,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        pll_lock,
  input  logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start
`ifdef LCD_TEST_PATTERN_EN
  ,
  output logic [23:0] rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  // 13-bit bounds so a region ending exactly at 4096 does not wrap to 0
  localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_check
      $error("lcd_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
    end
  endgenerate

  logic        r_lock_s1;
  logic        r_lock_s2;
  logic        r_run;
  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic        w_run;
  logic        w_active;
  logic        w_h_sync;
  logic        w_v_sync;
  logic        w_de;

  // r_run is the counter stage: the raster only runs once run has been seen for two edges
  assign w_run    = r_lock_s2 & enable;
  assign w_active = w_run & r_run;
  assign w_h_sync = ({1'b0, r_h_cnt} >= HS_BEG) && ({1'b0, r_h_cnt} < HS_END);
  assign w_v_sync = ({1'b0, r_v_cnt} >= VS_BEG) && ({1'b0, r_v_cnt} < VS_END);
  assign w_de     = ({1'b0, r_h_cnt} < H_ACT) && ({1'b0, r_v_cnt} < V_ACT);

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
      r_run     <= 1'b0;
    end else begin
      r_lock_s1 <= pll_lock;
      r_lock_s2 <= r_lock_s1;
      r_run     <= w_run;
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_h_cnt <= 12'd0;
      r_v_cnt <= 12'd0;
    end else if (!w_active) begin
      r_h_cnt <= 12'd0;
      r_v_cnt <= 12'd0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= 12'd0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? 12'd0 : r_v_cnt + 12'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 12'd1;
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= 12'd0;
      y           <= 12'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!w_active) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= 12'd0;
      y           <= 12'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= w_h_sync ? HS_POL : ~HS_POL;
      vsync       <= w_v_sync ? VS_POL : ~VS_POL;
      de          <= w_de;
      line_start  <= (r_h_cnt == 12'd0);
      frame_start <= (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
      if (w_de) begin
        x <= r_h_cnt;
        y <= r_v_cnt;
      end
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  localparam logic [11:0] BAR_W = (H_ACTIVE >= 8) ? 12'(H_ACTIVE / 8) : 12'd1;

  logic [11:0] w_bar;
  logic [2:0]  w_idx;

  assign w_bar = r_h_cnt / BAR_W;
  assign w_idx = (w_bar > 12'd7) ? 3'd7 : w_bar[2:0];

  // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0]
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      rgb <= 24'd0;
    end else if (!w_active || !w_de) begin
      rgb <= 24'd0;
    end else begin
      rgb <= {{8{~w_idx[1]}}, {8{~w_idx[2]}}, {8{~w_idx[0]}}};
    end
  end
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - self-checking bench for lcd_timing_gen against a raster-position model
module tb_lcd_timing_gen;

`ifdef LCD_TEST_PATTERN_EN
  localparam int HA = 16;
`else
  localparam int HA = 4;
`endif
  localparam int HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clkin = 1'b0;
  logic        reset;
  logic        pll_lock;
  logic        enable;
  logic        hsync, vsync, de, line_start, frame_start;
  logic [11:0] x, y;
`ifdef LCD_TEST_PATTERN_EN
  logic [23:0] rgb;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [23:0] e_rgb;
`endif

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .enable(enable),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
`ifdef LCD_TEST_PATTERN_EN
    , .rgb(rgb)
`endif
  );

  always #5 clkin = ~clkin;

  int passed = 0;
  int total  = 0;

  // Model state: lock/enable as seen at recent edges and the linear pixel position of the frame
  bit lh [4];
  bit eh [2];
  int pos = 0;
  logic e_hs, e_vs, e_de, e_ls, e_fs;
  logic [11:0] e_x, e_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int h, v;
    bit active;
    @(posedge clkin);
    if (reset) begin
      for (int i = 0; i < 4; i++) lh[i] = 1'b0;
      eh[0] = 1'b0; eh[1] = 1'b0;
      active = 1'b0;
    end else begin
      for (int i = 3; i > 0; i--) lh[i] = lh[i-1];
      lh[0] = pll_lock;
      eh[1] = eh[0];
      eh[0] = enable;
      // Two sync edges plus one counter edge before a run becomes visible
      active = lh[2] && lh[3] && eh[0] && eh[1];
    end
    if (active) begin
      h = pos % HT;
      v = pos / HT;
      e_de = (h < HA) && (v < VA);
      e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
      e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
      e_ls = (h == 0);
      e_fs = (pos == 0);
      if (e_de) begin
        e_x = 12'(h);
        e_y = 12'(v);
      end
      pos = (pos + 1) % FT;
    end else begin
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
      e_x = 12'd0; e_y = 12'd0;
      pos = 0;
    end
    #1;
    chk("ctrl", {27'd0, hsync, vsync, de, line_start, frame_start},
                {27'd0, e_hs, e_vs, e_de, e_ls, e_fs});
    chk("xy", {8'd0, y, x}, {8'd0, e_y, e_x});
`ifdef LCD_TEST_PATTERN_EN
    e_rgb = e_de ? bars[e_x / (HA / 8)] : 24'd0;
    chk("rgb", {8'd0, rgb}, {8'd0, e_rgb});
`endif
  endtask

  initial begin
    int lat, n_de, n_hs, n_vs, n_ls, n_fs;
    reset = 1'b1; pll_lock = 1'b0; enable = 1'b1;

    // Lock toggling under reset must not disturb the outputs
    for (int i = 0; i < 8; i++) begin
      step();
      pll_lock = ~pll_lock;
    end
    chk("reset_out", {hsync, vsync, de, frame_start, x, y}, {1'b1, 1'b1, 1'b0, 1'b0, 24'd0});

    reset = 1'b0; pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (frame_start === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("startup_latency", 32'(lat), 32'd4);

    n_de = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0;
    for (int i = 0; i < FT; i++) begin
      if (i > 0) step();
      n_de += int'(de); n_hs += int'(!hsync); n_vs += int'(!vsync);
      n_ls += int'(line_start); n_fs += int'(frame_start);
    end
    chk("de_per_frame", 32'(n_de), 32'(HA * VA));
    chk("hsync_per_frame", 32'(n_hs), 32'(HS * VT));
    chk("vsync_per_frame", 32'(n_vs), 32'(VS * HT));
    chk("lines_per_frame", 32'(n_ls), 32'(VT));
    chk("frames_per_frame", 32'(n_fs), 32'd1);
    step();
    chk("frame_period", {31'd0, frame_start}, 32'd1);

    // Abandon the frame at v=1, h=2 and restart
    for (int i = 0; i < 2 * FT && pos != HT + 2; i++) step();
    chk("drop_point", 32'(pos), 32'(HT + 2));
    pll_lock = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("drop_inactive", {hsync, vsync, de, line_start, x, y}, {1'b1, 1'b1, 1'b0, 1'b0, 24'd0});
    for (int i = 0; i < 4; i++) step();
    pll_lock = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (frame_start === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("restart_latency", 32'(lat), 32'd4);
    for (int i = 0; i < HA; i++) step();
    chk("restart_y", 32'(y), 32'd0);

    // Random lock/enable disturbance, mostly running
    for (int i = 0; i < 3000; i++) begin
      step();
      if (pll_lock) begin
        if ($urandom_range(0, 149) == 0) pll_lock = 1'b0;
      end else if ($urandom_range(0, 7) == 0) pll_lock = 1'b1;
      if (enable) begin
        if ($urandom_range(0, 299) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 4) == 0) enable = 1'b1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
